idct_transpose_buf: RTL and testbench



---
 rtl/idct_pkg.sv | 12 +
 rtl/idct_transpose_bank.sv | 41 ++++
 rtl/idct_transpose_buf.sv | 143 ++++++++++++++
 tb/tb_idct_transpose_buf.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared types and sizes for the JPEG IDCT datapath.
// Holds the block dimension, the coefficient and pixel widths, and the lane typedefs.
package idct_pkg;

  localparam int unsigned IDCT_N      = 8;
  localparam int unsigned IDCT_COEF_W = 16;
  localparam int unsigned IDCT_PIX_W  = 9;

  typedef logic signed [IDCT_COEF_W-1:0] idct_coef_t;
  typedef idct_coef_t [IDCT_N-1:0]       idct_vec_t;

endpackage

// File: rtl/idct_transpose_bank.sv
// One 8x8 coefficient bank: a whole row is written per cycle, a whole column is read.
// Ports:
//   clock       - clock
//   wr_en_i     - write the row in wr_data_i at row index wr_row_i
//   wr_row_i    - row index being written
//   wr_data_i   - 8-lane row data, lane k is column k
//   rd_col_i    - column index being read
//   rd_data_c_o - 8-lane column data, lane k is row k (combinational from storage)
// Contents have no reset; the owner's full flags say when a bank holds valid data.
module idct_transpose_bank
  import idct_pkg::*;
#(
  parameter int unsigned DATA_W = IDCT_COEF_W
) (
  input  logic                             clock,
  input  logic                             wr_en_i,
  input  logic [2:0]                       wr_row_i,
  input  logic [IDCT_N-1:0][DATA_W-1:0]    wr_data_i,
  input  logic [2:0]                       rd_col_i,
  output logic [IDCT_N-1:0][DATA_W-1:0]    rd_data_c_o
);

  logic [DATA_W-1:0] mem_q [IDCT_N][IDCT_N];

  // Row write
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      for (int k = 0; k < int'(IDCT_N); k++) begin
        mem_q[wr_row_i][k] <= wr_data_i[k];
      end
    end
  end

  // Column read
  always_comb begin
    for (int k = 0; k < int'(IDCT_N); k++) begin
      rd_data_c_o[k] = mem_q[k][rd_col_i];
    end
  end

endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong row/column transpose buffer between the row and column IDCT passes.
// Rows enter one per handshake, columns leave one per handshake; one bank fills
// while the other drains so a row and a column can move every cycle.
// Ports:
//   clock, reset            - clock, asynchronous active-low reset
//   in_valid / in_ready     - row handshake; in_ready depends only on registers
//   in0_d..in7_d            - row lanes, lane k = column k
//   out_valid / out_ready   - column handshake; out_valid depends only on registers
//   out0_d..out7_d          - column lanes, lane k = row k; zero when out_valid=0
//   out_zero                - present only with IDCT_TRANSPOSE_ZERO_EN: current column all zero
// Optional feature macro: IDCT_TRANSPOSE_ZERO_EN.
module idct_transpose_buf
  import idct_pkg::*;
#(
  parameter int unsigned DATA_W = IDCT_COEF_W,
  parameter int unsigned N      = IDCT_N
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in0_d,
  input  logic [DATA_W-1:0] in1_d,
  input  logic [DATA_W-1:0] in2_d,
  input  logic [DATA_W-1:0] in3_d,
  input  logic [DATA_W-1:0] in4_d,
  input  logic [DATA_W-1:0] in5_d,
  input  logic [DATA_W-1:0] in6_d,
  input  logic [DATA_W-1:0] in7_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out0_d,
  output logic [DATA_W-1:0] out1_d,
  output logic [DATA_W-1:0] out2_d,
  output logic [DATA_W-1:0] out3_d,
  output logic [DATA_W-1:0] out4_d,
  output logic [DATA_W-1:0] out5_d,
  output logic [DATA_W-1:0] out6_d,
  output logic [DATA_W-1:0] out7_d
`ifdef IDCT_TRANSPOSE_ZERO_EN
  ,
  output logic              out_zero
`endif
);

  // Only the 8x8 block is supported
  if (N != IDCT_N) begin : g_bad_n
    $error("idct_transpose_buf: N must be 8");
  end

  logic                          wr_bank_q, wr_bank_d;
  logic [2:0]                    wr_row_q,  wr_row_d;
  logic                          rd_bank_q, rd_bank_d;
  logic [2:0]                    rd_col_q,  rd_col_d;
  logic [1:0]                    full_q,    full_d;
  logic                          wr_fire_c, rd_fire_c;
  logic [IDCT_N-1:0][DATA_W-1:0] in_vec_c;
  logic [IDCT_N-1:0][DATA_W-1:0] rd0_c, rd1_c, rd_vec_c;

  assign in_vec_c = {in7_d, in6_d, in5_d, in4_d, in3_d, in2_d, in1_d, in0_d};

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire_c = in_valid && in_ready;
  assign rd_fire_c = out_valid && out_ready;

  idct_transpose_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clock       (clock),
    .wr_en_i     (wr_fire_c && !wr_bank_q),
    .wr_row_i    (wr_row_q),
    .wr_data_i   (in_vec_c),
    .rd_col_i    (rd_col_q),
    .rd_data_c_o (rd0_c)
  );

  idct_transpose_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clock       (clock),
    .wr_en_i     (wr_fire_c && wr_bank_q),
    .wr_row_i    (wr_row_q),
    .wr_data_i   (in_vec_c),
    .rd_col_i    (rd_col_q),
    .rd_data_c_o (rd1_c)
  );

  // Pointer and flag next-state; a finishing write and a finishing read always
  // touch different banks, so both flag updates apply
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    full_d    = full_q;
    if (wr_fire_c) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (rd_fire_c) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  // Pointer and flag registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= 3'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
      full_q    <= full_d;
    end
  end

  // Column output, forced to zero while nothing is valid
  assign rd_vec_c = out_valid ? (rd_bank_q ? rd1_c : rd0_c) : '0;

  assign out0_d = rd_vec_c[0];
  assign out1_d = rd_vec_c[1];
  assign out2_d = rd_vec_c[2];
  assign out3_d = rd_vec_c[3];
  assign out4_d = rd_vec_c[4];
  assign out5_d = rd_vec_c[5];
  assign out6_d = rd_vec_c[6];
  assign out7_d = rd_vec_c[7];

`ifdef IDCT_TRANSPOSE_ZERO_EN
  // All-zero column flag for the column-pass shortcut
  assign out_zero = out_valid && (rd_vec_c == '0);
`endif

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Randomized bench for idct_transpose_buf with a queue-of-blocks reference model.
module tb_idct_transpose_buf;
  import idct_pkg::*;

  typedef logic [15:0] lane_t;
  typedef lane_t [7:0] row_t;
  typedef row_t  [7:0] blk_t;   // [row][col]

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  row_t in_row    = '0;
  wire  in_ready;
  wire  out_valid;
  wire  [7:0][15:0] out_row;
`ifdef IDCT_TRANSPOSE_ZERO_EN
  wire  out_zero;
`endif

  idct_transpose_buf dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0_d     (in_row[0]),
    .in1_d     (in_row[1]),
    .in2_d     (in_row[2]),
    .in3_d     (in_row[3]),
    .in4_d     (in_row[4]),
    .in5_d     (in_row[5]),
    .in6_d     (in_row[6]),
    .in7_d     (in_row[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0_d    (out_row[0]),
    .out1_d    (out_row[1]),
    .out2_d    (out_row[2]),
    .out3_d    (out_row[3]),
    .out4_d    (out_row[4]),
    .out5_d    (out_row[5]),
    .out6_d    (out_row[6]),
    .out7_d    (out_row[7])
`ifdef IDCT_TRANSPOSE_ZERO_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: completed blocks waiting to be read, plus the block being assembled
  blk_t blk_q[$];
  blk_t part;
  int   part_rows = 0;
  int   col_idx   = 0;

  function automatic void model_clear();
    blk_q.delete();
    part      = '0;
    part_rows = 0;
    col_idx   = 0;
  endfunction

  // Stimulus source and driver controls
  row_t src_q[$];
  int   rdy_mode  = 0;     // 0 fixed, 1 toggle, 2 random
  logic rdy_fixed = 1'b0;
  logic gap_en    = 1'b0;

  logic wr_fire_n = 1'b0;
  logic rd_fire_n = 1'b0;
  row_t cap_row   = '0;
  int   ready_low = 0;
  int   cols_seen = 0;

  always @(negedge reset) model_clear();

  // Compare process: every cycle, DUT against the model
  always @(negedge clock) begin
    row_t e;
    logic ev;
    e  = '0;
    ev = (blk_q.size() > 0);
    if (ev) for (int k = 0; k < 8; k++) e[k] = blk_q[0][k][col_idx];
    chk("in_ready", 128'(in_ready), 128'(blk_q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("out_d", 128'(out_row), 128'(e));
`ifdef IDCT_TRANSPOSE_ZERO_EN
    chk("out_zero", 128'(out_zero), 128'(ev && (e == '0)));
`endif
    wr_fire_n = reset && in_valid && in_ready;
    rd_fire_n = reset && out_valid && out_ready;
    cap_row   = in_row;
    if (reset && in_valid && !in_ready) ready_low++;
    if (rd_fire_n) cols_seen++;
  end

  // Model update on each accepted handshake
  always @(posedge clock) begin
    if (reset) begin
      if (rd_fire_n && blk_q.size() > 0) begin
        col_idx++;
        if (col_idx == 8) begin
          void'(blk_q.pop_front());
          col_idx = 0;
        end
      end
      if (wr_fire_n) begin
        part[part_rows] = cap_row;
        part_rows++;
        if (part_rows == 8) begin
          blk_q.push_back(part);
          part_rows = 0;
        end
      end
    end
  end

  // Input/ready driver; a presented row is held until accepted
  always @(posedge clock) begin
    logic hold;
    hold = in_valid && !wr_fire_n && (src_q.size() > 0);
    if (wr_fire_n && src_q.size() > 0) void'(src_q.pop_front());
    #1;
    if (hold) begin
      in_valid = 1'b1;
      in_row   = src_q[0];
    end else if (reset && src_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      in_valid = 1'b1;
      in_row   = src_q[0];
    end else begin
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) in_row[k] = 16'($urandom);
    end
    case (rdy_mode)
      1:       out_ready = !out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = rdy_fixed;
    endcase
  end

  function automatic blk_t rand_blk();
    blk_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = 16'($urandom);
    return b;
  endfunction

  task automatic push_block(input blk_t b);
    for (int r = 0; r < 8; r++) src_q.push_back(b[r]);
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(src_q.size() == 0 && blk_q.size() == 0 && !out_valid && !in_valid) && n < 2000);
    chk({"drain_", name}, 128'(n < 2000), 128'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t b;
    int   n;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_d", 128'(out_row), 128'(0));
    @(posedge clock); #3 reset = 1'b1;
    rdy_fixed = 1'b1;
    repeat (2) @(negedge clock);

    // Single block with a known pattern
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = 16'(16'h0100 * r + c);
    push_block(b);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < 30);
    chk("latency", 128'(n), 128'(9));
    chk("c0_l3", 128'(out_row[3]), 128'(16'h0300));
    chk("c0_l0", 128'(out_row[0]), 128'(16'h0000));
    @(negedge clock);
    chk("c1_l5", 128'(out_row[5]), 128'(16'h0501));
    @(negedge clock);
    chk("c2_l7", 128'(out_row[7]), 128'(16'h0702));
    wait_idle("single", n);

    // Back-to-back blocks at full rate
    ready_low = 0;
    for (int i = 0; i < 4; i++) push_block(rand_blk());
    wait_idle("b2b", n);
    chk("b2b_cycles", 128'(n), 128'(41));
    chk("b2b_ready_low", 128'(ready_low), 128'(0));

    // Full stall: 17 rows with the reader stopped
    rdy_fixed = 1'b0;
    repeat (2) @(negedge clock);
    push_block(rand_blk());
    push_block(rand_blk());
    b = rand_blk();
    src_q.push_back(b[0]);
    repeat (25) @(negedge clock);
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    chk("stall_row_held", 128'(src_q.size()), 128'(1));
    chk("stall_in_valid", 128'(in_valid), 128'(1));
    rdy_fixed = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 30);
    chk("stall_release", 128'(n), 128'(9));
    for (int r = 1; r < 8; r++) src_q.push_back(b[r]);
    wait_idle("stall", n);

    // Alternating backpressure on one block
    cols_seen = 0;
    rdy_mode  = 1;
    push_block(rand_blk());
    wait_idle("toggle", n);
    chk("toggle_cols", 128'(cols_seen), 128'(8));

    // Random backpressure and input gaps
    rdy_mode = 2;
    gap_en   = 1'b1;
    cols_seen = 0;
    for (int i = 0; i < 6; i++) push_block(rand_blk());
    wait_idle("random", n);
    chk("random_cols", 128'(cols_seen), 128'(48));
    rdy_mode = 0;
    gap_en   = 1'b0;

    // Reset in the middle of a block
    push_block(rand_blk());
    n = 0;
    while (part_rows < 5 && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("mid_rows_reached", 128'(part_rows >= 5), 128'(1));
    @(posedge clock); #3;
    reset = 1'b0;
    src_q.delete();
    @(negedge clock);
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_out_d", 128'(out_row), 128'(0));
    @(posedge clock); #3 reset = 1'b1;
    push_block(rand_blk());
    wait_idle("after_reset", n);

`ifdef IDCT_TRANSPOSE_ZERO_EN
    // Only column 3 nonzero
    b = '0;
    b[2][3] = 16'hFFF0;
    push_block(b);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < 30);
    for (int c = 0; c < 8; c++) begin
      chk("zero_flag", 128'(out_zero), 128'(c != 3));
      if (c == 3) chk("zero_col3_l2", 128'(out_row[2]), 128'(16'hFFF0));
      @(negedge clock);
    end
    wait_idle("zero", n);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
